alu_rs: RTL and testbench

ALU_RS -- requirements
Module: alu_rs

---
 rtl/alu_rs_pkg.sv | 45 ++++
 rtl/alu_rs_operand.sv | 63 ++++++
 rtl/alu_rs.sv | 137 +++++++++++++
 tb/tb_alu_rs.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// rtl/alu_rs_pkg.sv - shared types for the ALU reservation station and CDB
package data_types;

    // Plain 32-bit datapath word.
    typedef logic [31:0] word32_t;

    // Producer identities on the common data bus. NO_TAG marks an operand whose value is already present.
    typedef enum logic [2:0] {
        NO_TAG = 3'd0,
        ALU_1  = 3'd1,
        ALU_2  = 3'd2,
        ALU_3  = 3'd3,
        MUL_1  = 3'd4,
        MUL_2  = 3'd5,
        LSU_1  = 3'd6,
        LSU_2  = 3'd7
    } rs_tag_t;

    // ALU operations. ADDR is the idle/reset operation.
    typedef enum logic [3:0] {
        ADDR  = 4'd0,
        SUBR  = 4'd1,
        ANDR  = 4'd2,
        ORR   = 4'd3,
        XORR  = 4'd4,
        SLLR  = 4'd5,
        SRLR  = 4'd6,
        SRAR  = 4'd7,
        SLTR  = 4'd8,
        SLTUR = 4'd9
    } alu_op_t;

    // One common-data-bus broadcast.
    typedef struct packed {
        logic    valid;
        rs_tag_t tag;
        word32_t data;
    } cdb_t;

    // A broadcast matches a tag only when it is valid and carries a real producer tag.
    function automatic logic cdb_match(input cdb_t cdb, input rs_tag_t tag);
        return cdb.valid && (cdb.tag != NO_TAG) && (cdb.tag == tag);
    endfunction

endpackage

// File: rtl/alu_rs_operand.sv
// rtl/alu_rs_operand.sv - one reservation-station operand slot with dispatch load and CDB snoop
module rs_operand
    import data_types::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    clear_i,     // entry squashed or retired: drop presence
    input  logic    load_i,      // dispatch accepted this cycle
    input  logic    snoop_i,     // entry is waiting on producers
    input  rs_tag_t tag_i,
    input  word32_t val_i,
    input  cdb_t    cdb_i,
    output word32_t val_o,
    output logic    present_d_o  // presence after this edge, used by the FSM to go READY
);

    rs_tag_t tag_q, tag_d;
    word32_t val_q, val_d;
    logic    present_q, present_d;

    // Next slot contents: clear wins, then dispatch load (with CDB bypass), then snoop capture.
    always_comb begin
        tag_d     = tag_q;
        val_d     = val_q;
        present_d = present_q;
        if (clear_i) begin
            present_d = 1'b0;
        end else if (load_i) begin
            tag_d = tag_i;
            if (cdb_match(cdb_i, tag_i)) begin
                // Producer is broadcasting right now: take the bus value instead of waiting.
                val_d     = cdb_i.data;
                present_d = 1'b1;
            end else if (tag_i == NO_TAG) begin
                val_d     = val_i;
                present_d = 1'b1;
            end else begin
                val_d     = val_i;
                present_d = 1'b0;
            end
        end else if (snoop_i && !present_q && cdb_match(cdb_i, tag_q)) begin
            val_d     = cdb_i.data;
            present_d = 1'b1;
        end
    end

    // Slot registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_q     <= NO_TAG;
            val_q     <= '0;
            present_q <= 1'b0;
        end else begin
            tag_q     <= tag_d;
            val_q     <= val_d;
            present_q <= present_d;
        end
    end

    assign val_o       = val_q;
    assign present_d_o = present_d;

endmodule

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - single-entry ALU reservation station: dispatch, operand wakeup, issue, retire
module alu_rs
    import data_types::*;
#(
    parameter rs_tag_t TAG = ALU_1
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    flush_i,
    input  logic    disp_valid_i,
    input  alu_op_t disp_oper_i,
    input  rs_tag_t disp_rs1_tag_i,
    input  rs_tag_t disp_rs2_tag_i,
    input  word32_t disp_rs1_val_i,
    input  word32_t disp_rs2_val_i,
    input  cdb_t    cdb_i,
    output logic    busy_o,
    output alu_op_t oper_o,
    output word32_t rs1_val_o,
    output word32_t rs2_val_o,
    output logic    ready_o
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        WAITING = 2'd1,
        READY   = 2'd2,
        ISSUED  = 2'd3
    } state_t;

    state_t  state_q, state_d;
    alu_op_t oper_q, oper_d;

    logic load;
    logic snoop;
    logic done;
    logic clear;
    logic rs1_present_d;
    logic rs2_present_d;

    // Dispatch is only taken into an empty entry, and a same-cycle flush drops it.
    assign load  = (state_q == EMPTY) && disp_valid_i && !flush_i;
    assign snoop = (state_q == WAITING);
    // Our own result on the bus retires the entry.
    assign done  = (state_q == ISSUED) && cdb_match(cdb_i, TAG);
    assign clear = flush_i || done;

    rs_operand u_rs1 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear),
        .load_i      (load),
        .snoop_i     (snoop),
        .tag_i       (disp_rs1_tag_i),
        .val_i       (disp_rs1_val_i),
        .cdb_i       (cdb_i),
        .val_o       (rs1_val_o),
        .present_d_o (rs1_present_d)
    );

    rs_operand u_rs2 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear),
        .load_i      (load),
        .snoop_i     (snoop),
        .tag_i       (disp_rs2_tag_i),
        .val_i       (disp_rs2_val_i),
        .cdb_i       (cdb_i),
        .val_o       (rs2_val_o),
        .present_d_o (rs2_present_d)
    );

    // State register; async reset drops ready_o and busy_o immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: flush beats everything, otherwise follow operand presence and our own CDB tag.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (disp_valid_i) begin
                        state_d = (rs1_present_d && rs2_present_d) ? READY : WAITING;
                    end
                end
                WAITING: begin
                    if (rs1_present_d && rs2_present_d) begin
                        state_d = READY;
                    end
                end
                READY: begin
                    state_d = ISSUED;
                end
                ISSUED: begin
                    if (done) begin
                        state_d = EMPTY;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Outputs decoded straight from the state register.
    always_comb begin
        busy_o  = (state_q != EMPTY);
        ready_o = (state_q == READY);
    end

    // Operation is captured at dispatch and held until the next accepted dispatch.
    always_comb begin
        oper_d = load ? disp_oper_i : oper_q;
    end

    // Operation register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            oper_q <= ADDR;
        end else begin
            oper_q <= oper_d;
        end
    end

    assign oper_o = oper_q;

endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - scoreboard bench for alu_rs with directed vectors
module tb_alu_rs;
    import data_types::*;

    typedef struct {
        alu_op_t oper;
        word32_t a;
        word32_t b;
    } exp_t;

    logic    clk_i;
    logic    rst_i;
    logic    flush_i;
    logic    disp_valid_i;
    alu_op_t disp_oper_i;
    rs_tag_t disp_rs1_tag_i;
    rs_tag_t disp_rs2_tag_i;
    word32_t disp_rs1_val_i;
    word32_t disp_rs2_val_i;
    cdb_t    cdb_i;
    logic    busy_o;
    alu_op_t oper_o;
    word32_t rs1_val_o;
    word32_t rs2_val_o;
    logic    ready_o;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    alu_rs #(.TAG(ALU_1)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .disp_valid_i   (disp_valid_i),
        .disp_oper_i    (disp_oper_i),
        .disp_rs1_tag_i (disp_rs1_tag_i),
        .disp_rs2_tag_i (disp_rs2_tag_i),
        .disp_rs1_val_i (disp_rs1_val_i),
        .disp_rs2_val_i (disp_rs2_val_i),
        .cdb_i          (cdb_i),
        .busy_o         (busy_o),
        .oper_o         (oper_o),
        .rs1_val_o      (rs1_val_o),
        .rs2_val_o      (rs2_val_o),
        .ready_o        (ready_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_cdb(input logic v, input rs_tag_t t, input word32_t d);
        cdb_i.valid = v;
        cdb_i.tag   = t;
        cdb_i.data  = d;
    endtask

    task automatic dispatch(input alu_op_t op, input rs_tag_t t1, input word32_t v1,
                            input rs_tag_t t2, input word32_t v2);
        disp_valid_i   = 1'b1;
        disp_oper_i    = op;
        disp_rs1_tag_i = t1;
        disp_rs1_val_i = v1;
        disp_rs2_tag_i = t2;
        disp_rs2_val_i = v2;
    endtask

    task automatic idle();
        disp_valid_i = 1'b0;
        flush_i      = 1'b0;
        set_cdb(1'b0, NO_TAG, 32'd0);
    endtask

    // Retire the issued entry with our own tag and confirm it empties.
    task automatic retire(input string name);
        set_cdb(1'b1, ALU_1, 32'd31);
        tick();
        idle();
        check(name, 32'(busy_o), 32'd0);
    endtask

    // Monitor: every issue strobe must match the oldest expected issue.
    initial begin
        forever begin
            @(negedge clk_i);
            if (ready_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("issue_oper", 32'(oper_o), 32'(e.oper));
                    check("issue_rs1", rs1_val_o, e.a);
                    check("issue_rs2", rs2_val_o, e.b);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i          = 1'b0;
        disp_oper_i    = ADDR;
        disp_rs1_tag_i = NO_TAG;
        disp_rs2_tag_i = NO_TAG;
        disp_rs1_val_i = '0;
        disp_rs2_val_i = '0;
        idle();
        #1 rst_i = 1'b1;
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_oper", 32'(oper_o), 32'(ADDR));
        check("rst_rs1", rs1_val_o, 32'd0);
        check("rst_rs2", rs2_val_o, 32'd0);
        tick();
        tick();
        rst_i = 1'b0;
        tick();

        // Both operands present at dispatch: issue next cycle only.
        dispatch(ADDR, NO_TAG, 32'd43, NO_TAG, 32'hFFFF_FFF4);
        exp_q.push_back('{ADDR, 32'd43, 32'hFFFF_FFF4});
        check("t1_ready_n", 32'(ready_o), 32'd0);
        tick();
        idle();
        check("t1_ready_n1", 32'(ready_o), 32'd1);
        check("t1_busy_n1", 32'(busy_o), 32'd1);
        tick();
        check("t1_ready_n2", 32'(ready_o), 32'd0);
        check("t1_busy_issued", 32'(busy_o), 32'd1);
        retire("t1_retire");

        // rs1 waits on ALU_2; invalid and NO_TAG broadcasts must not wake it.
        dispatch(SUBR, ALU_2, 32'd0, NO_TAG, 32'd12);
        tick();
        idle();
        set_cdb(1'b0, ALU_2, 32'd88);
        check("t2_waiting_busy", 32'(busy_o), 32'd1);
        check("t2_waiting_ready", 32'(ready_o), 32'd0);
        tick();
        set_cdb(1'b1, NO_TAG, 32'd77);
        check("t2_invalid_cdb", 32'(ready_o), 32'd0);
        tick();
        set_cdb(1'b1, ALU_2, 32'd55);
        exp_q.push_back('{SUBR, 32'd55, 32'd12});
        check("t2_notag_cdb", 32'(ready_o), 32'd0);
        tick();
        idle();
        check("t2_ready", 32'(ready_o), 32'd1);
        check("t2_rs1_captured", rs1_val_o, 32'd55);
        tick();
        check("t2_ready_one_cycle", 32'(ready_o), 32'd0);
        retire("t2_retire");

        // Both operands wake from one broadcast.
        dispatch(ANDR, ALU_2, 32'd1, ALU_2, 32'd2);
        tick();
        idle();
        set_cdb(1'b1, ALU_2, 32'd7);
        exp_q.push_back('{ANDR, 32'd7, 32'd7});
        tick();
        idle();
        check("t3_ready", 32'(ready_o), 32'd1);
        tick();
        check("t3_ready_one_cycle", 32'(ready_o), 32'd0);
        retire("t3_retire");

        // Dispatch-cycle bypass on rs2.
        dispatch(ORR, NO_TAG, 32'h10, ALU_3, 32'd0);
        set_cdb(1'b1, ALU_3, 32'd5);
        exp_q.push_back('{ORR, 32'h10, 32'd5});
        tick();
        idle();
        check("t4_ready", 32'(ready_o), 32'd1);
        check("t4_rs2_bypass", rs2_val_o, 32'd5);
        tick();
        retire("t4_retire");

        // Dispatch while busy is ignored; flush empties; late CDB match is harmless.
        dispatch(XORR, ALU_3, 32'd0, NO_TAG, 32'd3);
        tick();
        dispatch(ADDR, NO_TAG, 32'd1, NO_TAG, 32'd2);
        tick();
        idle();
        check("t5_busy_kept", 32'(busy_o), 32'd1);
        check("t5_no_issue", 32'(ready_o), 32'd0);
        check("t5_oper_kept", 32'(oper_o), 32'(XORR));
        check("t5_rs2_kept", rs2_val_o, 32'd3);
        flush_i = 1'b1;
        tick();
        idle();
        check("t5_flush_empty", 32'(busy_o), 32'd0);
        set_cdb(1'b1, ALU_3, 32'd9);
        tick();
        idle();
        check("t5_late_cdb_busy", 32'(busy_o), 32'd0);
        check("t5_late_cdb_ready", 32'(ready_o), 32'd0);

        // Flush drops a same-cycle dispatch.
        dispatch(ADDR, NO_TAG, 32'd4, NO_TAG, 32'd4);
        flush_i = 1'b1;
        tick();
        idle();
        check("t6_flush_disp_busy", 32'(busy_o), 32'd0);
        tick();
        check("t6_flush_disp_ready", 32'(ready_o), 32'd0);

        // Async reset while ready_o is high.
        dispatch(SUBR, NO_TAG, 32'd5, NO_TAG, 32'd6);
        exp_q.push_back('{SUBR, 32'd5, 32'd6});
        tick();
        idle();
        check("t7_ready_before_rst", 32'(ready_o), 32'd1);
        @(negedge clk_i);
        #1 rst_i = 1'b1;
        #1;
        check("t7_rst_ready", 32'(ready_o), 32'd0);
        check("t7_rst_busy", 32'(busy_o), 32'd0);
        check("t7_rst_oper", 32'(oper_o), 32'(ADDR));
        check("t7_rst_rs1", rs1_val_o, 32'd0);
        check("t7_rst_rs2", rs2_val_o, 32'd0);
        tick();
        rst_i = 1'b0;
        tick();
        check("t7_after_rst_busy", 32'(busy_o), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
